adder_share_ctrl: RTL and testbench

- Shares one WIDTH-bit ripple-carry adder (33-bit result: sum plus carry-out) among NUM_REQ requesters.
- Round-robin arbitration with per-requester valid/ready on the operand side.
- Registered operand and result stages; a single response channel tagged with the requester ID.
- Sits between client blocks and the shared adder datapath; the adder remains purely combinational.

---
 rtl/adder_share_pkg.sv | 18 +
 rtl/ripple_adder.sv | 23 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/adder_share_ctrl.sv | 149 ++++++++++++++
 tb/tb_adder_share_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_share_pkg.sv
// rtl/adder_share_pkg.sv - shared defaults, FSM states and result type for adder_share_ctrl
package adder_share_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic                 carry;
    logic [DEF_WIDTH-1:0] sum;
  } add_res_t;

endpackage

// File: rtl/ripple_adder.sv
// rtl/ripple_adder.sv - purely combinational ripple-carry adder with carry-out
module ripple_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic c;

  always_comb begin
    c     = 1'b0;
    sum_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    carry_o = c;
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting the scan at ptr_i
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     gnt_idx_o,
  output logic               gnt_any_o
);

  int idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_any_o && req_i[IDW'(idx)]) begin
        gnt_any_o          = 1'b1;
        gnt_o[IDW'(idx)]   = 1'b1;
        gnt_idx_o          = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// rtl/adder_share_ctrl.sv - round-robin sharing of one adder among NUM_REQ requesters
// ADDER_SHARE_CTRL_STATS_EN adds the txn_count and busy outputs.
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int WIDTH   = DEF_WIDTH,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_in1,
  input  logic [NUM_REQ*WIDTH-1:0] req_in2,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IDW-1:0]           resp_id,
  output logic [WIDTH-1:0]         resp_sum,
  output logic                     resp_carry
`ifdef ADDER_SHARE_CTRL_STATS_EN
  ,
  output logic [15:0]              txn_count,
  output logic                     busy
`endif
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [IDW-1:0]   op_id_q, op_id_d;
  logic             resp_valid_q, resp_valid_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_sum_q, resp_sum_d;
  logic             resp_carry_q, resp_carry_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_idx;
  logic               gnt_any;
  logic               accept_win;
  logic               take;
  logic [WIDTH-1:0]   add_sum;
  logic               add_carry;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  ripple_adder #(.WIDTH(WIDTH)) u_add (
    .a_i     (op_a_q),
    .b_i     (op_b_q),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  // A new operand may only enter when the result slot is free or being drained this cycle.
  assign accept_win = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
  assign req_ready  = (accept_win && rst_n) ? gnt : '0;
  assign take       = accept_win && gnt_any;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_id_d      = op_id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_sum_d   = resp_sum_q;
    resp_carry_d = resp_carry_q;

    if (take) begin
      op_a_d   = req_in1[int'(gnt_idx)*WIDTH +: WIDTH];
      op_b_d   = req_in2[int'(gnt_idx)*WIDTH +: WIDTH];
      op_id_d  = gnt_idx;
      rr_ptr_d = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (take) state_d = ADD;
      end
      ADD: begin
        resp_sum_d   = add_sum;
        resp_carry_d = add_carry;
        resp_id_d    = op_id_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = take ? ADD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_id_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_sum_q   <= '0;
      resp_carry_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_id_q      <= op_id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_sum_q   <= resp_sum_d;
      resp_carry_q <= resp_carry_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;
  assign resp_carry = resp_carry_q;

`ifdef ADDER_SHARE_CTRL_STATS_EN
  logic [15:0] txn_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count_q <= '0;
    end else if (resp_valid_q && resp_ready) begin
      txn_count_q <= txn_count_q + 16'd1;
    end
  end

  assign txn_count = txn_count_q;
  assign busy      = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb/tb_adder_share_ctrl.sv - scoreboard bench for adder_share_ctrl (ADDER_SHARE_CTRL_STATS_EN adds stats checks)
module tb_adder_share_ctrl;
  import adder_share_pkg::*;

  localparam int NR  = 4;
  localparam int W   = 32;
  localparam int IDW = $clog2(NR);

  typedef struct {
    logic [IDW-1:0] id;
    add_res_t       res;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*W-1:0] req_in1;
  logic [NR*W-1:0] req_in2;
  logic            resp_valid;
  logic            resp_ready;
  logic [IDW-1:0]  resp_id;
  logic [W-1:0]    resp_sum;
  logic            resp_carry;
`ifdef ADDER_SHARE_CTRL_STATS_EN
  logic [15:0]     txn_count;
  logic            busy;
`endif

  exp_t sb[$];
  int   rd_idx   = 0;
  int   tb_txn   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  adder_share_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_in1    (req_in1),
    .req_in2    (req_in2),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_carry (resp_carry)
`ifdef ADDER_SHARE_CTRL_STATS_EN
    ,
    .txn_count  (txn_count),
    .busy       (busy)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic add_res_t model_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b};
    return add_res_t'(full);
  endfunction

  task automatic push_exp(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.id  = IDW'(i);
    e.res = model_add(a, b);
    sb.push_back(e);
  endtask

  task automatic drive(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_in1[i*W +: W] = a;
    req_in2[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_one(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    int c;
    c = 0;
    push_exp(i, a, b);
    drive(i, a, b);
    req_valid[i] = 1'b1;
    do begin
      @(negedge clk);
      c++;
    end while (!req_ready[i] && c < 20);
    check_eq("send_grant", 64'(req_ready), 64'(1 << i));
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while (rd_idx < sb.size() && c < 50) begin
      @(negedge clk);
      #1 c++;
    end
    check_eq(tag, 64'(sb.size() - rd_idx), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every consumed result must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_idx <= sb.size();
      tb_txn <= 0;
    end else if (resp_valid && resp_ready) begin
      tb_txn <= tb_txn + 1;
      check_eq("resp_pending", 64'(sb.size() > rd_idx), 64'd1);
      if (sb.size() > rd_idx) begin
        check_eq("resp_id",    64'(resp_id),    64'(sb[rd_idx].id));
        check_eq("resp_sum",   64'(resp_sum),   64'(sb[rd_idx].res.sum));
        check_eq("resp_carry", 64'(resp_carry), 64'(sb[rd_idx].res.carry));
        rd_idx <= rd_idx + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int c;
    int hs;
    int last;
    add_res_t r1;

    rst_n      = 1'b0;
    req_valid  = '0;
    req_in1    = '0;
    req_in2    = '0;
    resp_ready = 1'b1;

    // Reset then idle
    @(posedge clk);
    #1 req_valid = '1;
    @(negedge clk);
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("idle_resp_valid", 64'(resp_valid), 64'd0);
      check_eq("idle_req_ready", 64'(req_ready), 64'd0);
    end
    check_eq("idle_sum", 64'(resp_sum), 64'd0);
    check_eq("idle_id", 64'(resp_id), 64'd0);
    check_eq("idle_carry", 64'(resp_carry), 64'd0);
`ifdef ADDER_SHARE_CTRL_STATS_EN
    check_eq("idle_txn_count", 64'(txn_count), 64'd0);
    check_eq("idle_busy", 64'(busy), 64'd0);
`endif

    // Single request with latency check
    @(posedge clk);
    #1 push_exp(2, 32'h5, 32'h3);
    drive(2, 32'h5, 32'h3);
    req_valid[2] = 1'b1;
    @(negedge clk);
    check_eq("single_ready", 64'(req_ready), 64'(4'b0100));
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    @(negedge clk);
    check_eq("single_add_valid", 64'(resp_valid), 64'd0);
    check_eq("single_add_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    check_eq("single_resp_valid", 64'(resp_valid), 64'd1);
    drain("single_drain");

    // Wrap / carry and random operands
    send_one(0, 32'hFFFF_FFFF, 32'h0000_0001);
    send_one(1, 32'h8000_0000, 32'h8000_0000);
    for (int k = 0; k < 6; k++) begin
      send_one(int'($urandom_range(0, NR - 1)), W'($urandom), W'($urandom));
    end
    drain("wrap_drain");
`ifdef ADDER_SHARE_CTRL_STATS_EN
    check_eq("wrap_txn_count", 64'(txn_count), 64'(tb_txn));
`endif

    // Fairness: all requesters hold valid from rr_ptr=0
    do_reset();
    for (int i = 0; i < NR; i++) drive(i, 32'hF000_0000 + W'(i), 32'h1000_0000 * W'(i + 1));
    for (int k = 0; k < 2 * NR; k++) push_exp(k % NR, 32'hF000_0000 + W'(k % NR), 32'h1000_0000 * W'(k % NR + 1));
    req_valid = '1;
    hs = 0;
    last = 0;
    c = 0;
    while (hs < 2 * NR && c < 100) begin
      @(negedge clk);
      c++;
      if (req_ready != '0) begin
        check_eq("fair_grant", 64'(req_ready), 64'(1 << (hs % NR)));
        if (hs > 0) check_eq("fair_spacing", 64'(c - last), 64'd2);
        last = c;
        hs++;
        if (hs == 2 * NR) begin
          @(posedge clk);
          #1 req_valid = '0;
        end
      end
    end
    check_eq("fair_handshakes", 64'(hs), 64'(2 * NR));
    req_valid = '0;
    drain("fair_drain");

    // Backpressure: result held while resp_ready=0, req 3 granted on release
    resp_ready = 1'b0;
    drive(1, 32'h1234_5678, 32'h1111_1111);
    drive(3, 32'hCAFE_0000, 32'h0000_BABE);
    push_exp(1, 32'h1234_5678, 32'h1111_1111);
    r1 = model_add(32'h1234_5678, 32'h1111_1111);
    req_valid = 4'b1010;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (req_ready == '0 && c < 20);
    check_eq("bp_first_grant", 64'(req_ready), 64'(4'b0010));
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    check_eq("bp_add_ready", 64'(req_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_hold_valid", 64'(resp_valid), 64'd1);
      check_eq("bp_hold_id", 64'(resp_id), 64'd1);
      check_eq("bp_hold_sum", 64'(resp_sum), 64'(r1.sum));
      check_eq("bp_hold_carry", 64'(resp_carry), 64'(r1.carry));
      check_eq("bp_hold_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    push_exp(3, 32'hCAFE_0000, 32'h0000_BABE);
    @(negedge clk);
    check_eq("bp_release_grant", 64'(req_ready), 64'(4'b1000));
    @(posedge clk);
    #1 req_valid[3] = 1'b0;
    drain("bp_drain");

    // Async reset while in ADD
    send_one(2, 32'h0000_0007, 32'h0000_0009);
`ifdef ADDER_SHARE_CTRL_STATS_EN
    check_eq("add_busy", 64'(busy), 64'd1);
`endif
    req_valid = '1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_add_valid", 64'(resp_valid), 64'd0);
    check_eq("arst_add_ready", 64'(req_ready), 64'd0);
    check_eq("arst_add_sum", 64'(resp_sum), 64'd0);
`ifdef ADDER_SHARE_CTRL_STATS_EN
    check_eq("arst_txn_count", 64'(txn_count), 64'd0);
    check_eq("arst_busy", 64'(busy), 64'd0);
`endif
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Async reset while a result is waiting in RESP
    resp_ready = 1'b0;
    send_one(2, 32'h0000_0100, 32'h0000_0200);
    @(negedge clk);
    @(negedge clk);
    check_eq("arst_resp_pre", 64'(resp_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    resp_ready = 1'b1;

    // rr_ptr must restart at 0 after reset
    drive(0, 32'h0000_0AAA, 32'h0000_0555);
    drive(3, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    push_exp(0, 32'h0000_0AAA, 32'h0000_0555);
    push_exp(3, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    req_valid = 4'b1001;
    @(negedge clk);
    check_eq("rst_ptr_grant", 64'(req_ready), 64'(4'b0001));
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (req_ready == '0 && c < 20);
    check_eq("rst_ptr_second", 64'(req_ready), 64'(4'b1000));
    @(posedge clk);
    #1 req_valid[3] = 1'b0;
    drain("final_drain");
`ifdef ADDER_SHARE_CTRL_STATS_EN
    check_eq("final_txn_count", 64'(txn_count), 64'(tb_txn));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
